// File: rtl/axi_arbiter_stom_s3.sv
// Slave-to-master response arbiter: round-robin B grant per beat, R grant locked
// to one slave from its first beat through RLAST.
module axi_arbiter_stom_s3 #(
   parameter int unsigned WIDTH_CID = 4,
   parameter int unsigned WIDTH_ID  = 4,
   parameter int unsigned WIDTH_SID = WIDTH_CID + WIDTH_ID,
   parameter int unsigned NUM       = 3
) (
   input  logic           ARESETn,
   input  logic           ACLK,
   input  logic [NUM-1:0] BSELECT,
   input  logic [NUM-1:0] BVALID,
   input  logic [NUM-1:0] BREADY,
   output logic [NUM-1:0] BGRANT,
   input  logic [NUM-1:0] RSELECT,
   input  logic [NUM-1:0] RVALID,
   input  logic [NUM-1:0] RREADY,
   input  logic [NUM-1:0] RLAST,
   output logic [NUM-1:0] RGRANT
);

   if (NUM < 2 || WIDTH_SID < WIDTH_CID + WIDTH_ID) begin : g_bad_param
      $error("axi_arbiter_stom_s3: unsupported parameter set");
   end

   // Reset pointer sits on the top slave so the search begins at slave0.
   localparam logic [NUM-1:0] LastRst = {1'b1, {(NUM-1){1'b0}}};

   typedef enum logic [0:0] {StBRun = 1'b0, StBWait = 1'b1} b_state_e;
   typedef enum logic [0:0] {StRRun = 1'b0, StRLock = 1'b1} r_state_e;

   b_state_e       r_b_state;
   r_state_e       r_r_state;
   logic [NUM-1:0] r_bgrant;
   logic [NUM-1:0] r_rgrant;
   logic [NUM-1:0] r_last_b;
   logic [NUM-1:0] r_last_r;

   logic [NUM-1:0] w_breq;
   logic [NUM-1:0] w_rreq;
   logic [NUM-1:0] w_bpick;
   logic [NUM-1:0] w_rpick;
   logic           w_r_hs;
   logic           w_r_last;

   // First requester found scanning upward from the slot after the one-hot pointer.
   function automatic logic [NUM-1:0] rr_pick(input logic [NUM-1:0] req,
                                              input logic [NUM-1:0] last);
      logic [NUM-1:0] grant;
      int             start;
      int             idx;
      grant = '0;
      start = 0;
      for (int i = 0; i < int'(NUM); i++) begin
         if (last[i]) start = (i + 1) % int'(NUM);
      end
      for (int k = 0; k < int'(NUM); k++) begin
         idx = (start + k) % int'(NUM);
         if (grant == '0 && req[idx]) grant[idx] = 1'b1;
      end
      return grant;
   endfunction

   assign w_breq   = BSELECT & BVALID;
   assign w_rreq   = RSELECT & RVALID;
   assign w_bpick  = rr_pick(w_breq, r_last_b);
   assign w_rpick  = rr_pick(w_rreq, r_last_r);
   assign w_r_hs   = |(w_rpick & RVALID & RREADY);
   assign w_r_last = |(w_rpick & RLAST);

   always_comb begin
      BGRANT = w_bpick;
      if (r_b_state == StBWait) BGRANT = r_bgrant;
   end

   always_comb begin
      RGRANT = w_rpick;
      if (r_r_state == StRLock) RGRANT = r_rgrant;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_b_state <= StBRun;
         r_bgrant  <= '0;
         r_last_b  <= LastRst;
      end else begin
         case (r_b_state)
            StBRun: begin
               if (w_bpick != '0) begin
                  if ((w_bpick & BREADY) != '0) begin
                     r_last_b <= w_bpick;
                  end else begin
                     r_bgrant  <= w_bpick;
                     r_b_state <= StBWait;
                  end
               end
            end
            StBWait: begin
               // Held grant ignores newcomers until its own handshake completes.
               if (|(r_bgrant & BVALID & BREADY)) begin
                  r_last_b  <= r_bgrant;
                  r_bgrant  <= '0;
                  r_b_state <= StBRun;
               end
            end
            default: begin
               r_bgrant  <= '0;
               r_b_state <= StBRun;
            end
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_r_state <= StRRun;
         r_rgrant  <= '0;
         r_last_r  <= LastRst;
      end else begin
         case (r_r_state)
            StRRun: begin
               if (w_r_hs && w_r_last) begin
                  r_last_r <= w_rpick;
               end else if (w_rpick != '0) begin
                  r_rgrant  <= w_rpick;
                  r_r_state <= StRLock;
               end
            end
            StRLock: begin
               // Lock survives RVALID gaps; only the owner's final beat releases it.
               if (|(r_rgrant & RVALID & RREADY & RLAST)) begin
                  r_last_r  <= r_rgrant;
                  r_rgrant  <= '0;
                  r_r_state <= StRRun;
               end
            end
            default: begin
               r_rgrant  <= '0;
               r_r_state <= StRRun;
            end
         endcase
      end
   end

endmodule
